// File: rtl/dsp_simd2x_int9xuint8_cascade_add_stim.sv
// Stimulus generator for the SIMD 2x INT9xUINT8 cascade-add unit: directed corners, then LFSR vectors,
// plus latency-aligned reference copies. Define STIM_CORNER_EN to include the directed corner phase.
module dsp_simd2x_int9xuint8_cascade_add_stim #(
  parameter int unsigned NUM_TESTS   = 1024,
  parameter int unsigned DUV_LATENCY = 3,
  parameter logic [63:0] SEED        = 64'hACE1_2022_0316_BEEF
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              stim_valid_o,
  output logic [7:0]        a_out_o [2],
  output logic [7:0]        b_out_o [2],
  output logic signed [8:0] coeff_out_o [2],
  output logic [7:0]        a_ref_o [2],
  output logic [7:0]        b_ref_o [2],
  output logic signed [8:0] coeff_ref_o [2],
  output logic              scoreboard_en_o,
  output logic              scoreboard_reset_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned VEC_W  = 2 * COEF_W + 4 * DATA_W;
  localparam logic [31:0] LAST_IDX  = 32'(NUM_TESTS - 1);
  localparam logic [31:0] DRAIN_END = 32'(DUV_LATENCY - 1);
  localparam logic [63:0] SEED_EFF  = (SEED == 64'h0) ? 64'h1 : SEED;
`ifdef STIM_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_CORNER, ST_RANDOM, ST_DRAIN, ST_DONE
  } state_e;

  // Operand vector packing {c1, c0, b1, b0, a1, a0} matches the LFSR field mapping bit for bit.
  function automatic logic [VEC_W-1:0] corner_vec(input logic [1:0] idx);
    case (idx)
      2'd0:    corner_vec = {9'h100, 9'h100, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      2'd1:    corner_vec = {9'h0FF, 9'h0FF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      2'd2:    corner_vec = {9'h100, 9'h100, 8'h00, 8'h00, 8'h00, 8'h00};
      default: corner_vec = {9'h001, 9'h1FF, 8'hFE, 8'h01, 8'h7F, 8'h80};
    endcase
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    lfsr_next = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        drain_q, drain_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sbrst_q, sbrst_d;
  logic               issue;
  logic [VEC_W-1:0]   vec_p_q [DUV_LATENCY];
  logic               vld_p_q [DUV_LATENCY];

  // busy/done/scoreboard_reset are computed from the current state so they land registered one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = (state_q == ST_DONE);
    sbrst_d = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
          lfsr_d  = SEED_EFF;
          cnt_d   = '0;
          drain_d = '0;
          busy_d  = 1'b1;
          sbrst_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy_d = 1'b1;
        issue  = 1'b1;
      end
      ST_CORNER, ST_RANDOM: begin
        busy_d = 1'b1;
        issue  = !hold_i;
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (drain_q == DRAIN_END) state_d = ST_DONE;
        else                      drain_d = drain_q + 32'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A vector issued this cycle is visible on the operand outputs next cycle.
    if (issue) begin
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
      if (CORNER_EN && cnt_q < 32'd4) begin
        vec_d = corner_vec(cnt_q[1:0]);
      end else begin
        vec_d  = lfsr_q[VEC_W-1:0];
        lfsr_d = lfsr_next(lfsr_q);
      end
      if (cnt_q == LAST_IDX)                  state_d = ST_DRAIN;
      else if (CORNER_EN && cnt_q < 32'd3)    state_d = ST_CORNER;
      else                                    state_d = ST_RANDOM;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      lfsr_q  <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sbrst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sbrst_q <= sbrst_d;
    end
  end

  // Reference delay line: shifts every cycle, hold or not, so it tracks the DUV pipeline.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DUV_LATENCY); i++) begin
        vec_p_q[i] <= '0;
        vld_p_q[i] <= 1'b0;
      end
    end else begin
      vec_p_q[0] <= vec_q;
      vld_p_q[0] <= valid_q;
      for (int i = 1; i < int'(DUV_LATENCY); i++) begin
        vec_p_q[i] <= vec_p_q[i-1];
        vld_p_q[i] <= vld_p_q[i-1];
      end
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign stim_valid_o       = valid_q;
  assign scoreboard_reset_o = sbrst_q;
  assign scoreboard_en_o    = vld_p_q[DUV_LATENCY-1];

  assign a_out_o[0]     = vec_q[7:0];
  assign a_out_o[1]     = vec_q[15:8];
  assign b_out_o[0]     = vec_q[23:16];
  assign b_out_o[1]     = vec_q[31:24];
  assign coeff_out_o[0] = signed'(vec_q[40:32]);
  assign coeff_out_o[1] = signed'(vec_q[49:41]);

  assign a_ref_o[0]     = vec_p_q[DUV_LATENCY-1][7:0];
  assign a_ref_o[1]     = vec_p_q[DUV_LATENCY-1][15:8];
  assign b_ref_o[0]     = vec_p_q[DUV_LATENCY-1][23:16];
  assign b_ref_o[1]     = vec_p_q[DUV_LATENCY-1][31:24];
  assign coeff_ref_o[0] = signed'(vec_p_q[DUV_LATENCY-1][40:32]);
  assign coeff_ref_o[1] = signed'(vec_p_q[DUV_LATENCY-1][49:41]);

endmodule

// File: doc/dsp_simd2x_int9xuint8_cascade_add_stim.md
# dsp_simd2x_int9xuint8_cascade_add_stim

Synthesizable stimulus generator that drives the DSP SIMD 2x INT9xUINT8 cascade-add unit and its reference model. It also produces latency-aligned operand copies and the enable/reset controls for the cascade-add scoreboard. The bench instantiates it between the test sequencer (start/hold/done) and the DUV/reference/scoreboard trio. It emits a directed corner-case phase followed by an LFSR-driven random phase.

## Interface
- NUM_TESTS, 1024: total vectors per run (corner + random); legal range ≥1.
- DUV_LATENCY, 3: DUV/reference pipeline depth in cycles; legal range ≥1.
- SEED, 64'hACE1_2022_0316_BEEF: LFSR load value at run start; 0 is replaced by 64'h1.
- clk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled in IDLE only.
- hold  in  1  pause vector generation while high.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the final scoreboard compare.
- stim_valid  out  1  a/b/coeff outputs carry a new vector this cycle.
- a_out[0:1]  out  8 each  unsigned pixel operands A1, A2.
- b_out[0:1]  out  8 each  unsigned pixel operands B1, B2.
- coeff_out[0:1]  out  9 each, signed  coefficients C1, C2.
- a_ref[0:1], b_ref[0:1], coeff_ref[0:1]  out  8/8/9  operands delayed by DUV_LATENCY, for scoreboard messages.
- scoreboard_en  out  1  stim_valid delayed by DUV_LATENCY.
- scoreboard_reset  out  1  one-cycle statistics clear at run start.

## Operation
- FSM states: IDLE, CLEAR, CORNER, RANDOM, DRAIN, DONE.
- IDLE: start=1 -> CLEAR. The LFSR loads SEED, and the vector counter and drain counter clear.
- CLEAR: scoreboard_reset=1 for exactly one cycle. Next state is CORNER, or RANDOM without the corner feature.
- CORNER: emits corner vectors 0..min(4,NUM_TESTS)-1, one per non-held cycle. Then goes to RANDOM if NUM_TESTS>4, else DRAIN.
- Corner vectors (a0,a1,b0,b1,c0,c1):
  - 0: 255,255,255,255,-256,-256
  - 1: 255,255,255,255,255,255
  - 2: 0,0,0,0,-256,-256
  - 3: 128,127,1,254,-1,1
- RANDOM: emits one vector per non-held cycle, then steps the LFSR. After vector NUM_TESTS-1 -> DRAIN.
- LFSR: 64-bit Fibonacci, polynomial x^64+x^63+x^61+x^60+1. Next = {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}.
- LFSR field mapping: a0=[7:0], a1=[15:8], b0=[23:16], b1=[31:24], c0=[40:32], c1=[49:41] (two's complement).
- DRAIN: counts DUV_LATENCY cycles, then -> DONE. hold is ignored in DRAIN.
- DONE: done=1 for one cycle -> IDLE.
- busy=1 in CLEAR, CORNER, RANDOM and DRAIN.
- hold=1 in CORNER/RANDOM: stim_valid=0; operand outputs, LFSR, counter and state are frozen. The delay line still shifts, so scoreboard_en follows the delayed stim_valid.
- start outside IDLE is ignored. hold in IDLE/CLEAR/DONE has no effect.
- Reset, including mid-run: all outputs, delay-line stages, counters and LFSR clear to 0. State -> IDLE. Nothing is emitted afterwards until a new start.

## Timing
- All outputs are registered.
- start high at cycle 0 -> scoreboard_reset=1 at cycle 1 -> first stim_valid at cycle 2.
- A vector emitted at cycle k appears on *_ref with scoreboard_en=1 at cycle k+DUV_LATENCY, matching DUV result timing.
- With H held cycles, last vector at cycle NUM_TESTS+1+H. done at cycle NUM_TESTS+2+H+DUV_LATENCY, which is one cycle after the last scoreboard_en.
- Operand outputs keep their last value when stim_valid=0.

## Configuration
- STIM_CORNER_EN defined: the CORNER phase is included, and the first min(4,NUM_TESTS) vectors are the directed corners.
- STIM_CORNER_EN undefined: CLEAR -> RANDOM directly, and all NUM_TESTS vectors come from the LFSR. Timing is otherwise identical.

## Test plan
- Corner values: reset, start with DUV_LATENCY=3 and STIM_CORNER_EN defined.
  - Vector 0 (a=255, c=-256) appears at cycle 2.
  - The same values appear on a_ref/coeff_ref with scoreboard_en=1 at cycle 5.
- Run length: NUM_TESTS=8, no hold.
  - Exactly 8 stim_valid and 8 scoreboard_en pulses.
  - done at cycle 13; busy low from cycle 13.
- Hold: assert hold for 5 cycles during RANDOM.
  - stim_valid=0 and outputs frozen for 5 cycles.
  - The LFSR sequence resumes unbroken; done is delayed by 5 cycles.
- Seeding: SEED=0.
  - The first random vector is derived from an LFSR state of 64'h1, not all-zero.
  - Without STIM_CORNER_EN, vector 0 fields equal the SEED mapping.
- Reset mid-run: drop aresetn at cycle 20.
  - All outputs are 0 the same cycle and the FSM is IDLE.
  - A subsequent start restarts with scoreboard_reset and vector 0.
- Start while busy: pulse start during RANDOM.
  - Ignored: no second scoreboard_reset, and the vector count is unchanged.
